// File: rtl/fix_message_tx.sv
// Transmit-side FIX 4.2 session message builder: turns a message-type request into a
// fixed 44-byte frame on a byte stream and keeps a per-host BCD MsgSeqNum counter.
module fix_message_tx #(
  parameter int HOST_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              initiate_msg_i,
  input  logic [3:0]        create_message_i,
  input  logic [HOST_W-1:0] host_i,
  input  logic              seq_reset_i,
  input  logic [HOST_W-1:0] seq_reset_host_i,
  output logic              ready_o,
  output logic              err_o,
  output logic [7:0]        data_o,
  output logic              valid_o,
  output logic              sop_o,
  output logic              eop_o,
  input  logic              ready_i,
  output logic              dbg_state_o
);

  // Handshakes: a request is consumed on a rising edge with initiate_msg_i && ready_o;
  // a byte transfers on a rising edge with valid_o && ready_i, and while valid_o is high
  // with ready_i low, data_o/sop_o/eop_o hold their values.

  localparam int         NHOST    = 1 << HOST_W;
  localparam logic [7:0] SOH      = 8'h01;
  localparam logic [5:0] LAST_IDX = 6'd43;
  localparam logic [5:0] CS_LAST  = 6'd36;

  typedef enum logic {IDLE, SEND} state_e;

  state_e            state_q, state_d;
  logic [5:0]        idx_q;
  logic [7:0]        t_q;
  logic [23:0]       snap_q;
  logic [HOST_W-1:0] host_q;
  logic [7:0]        csum_q;
  logic [23:0]       seq_all [NHOST];

  logic       code_ok;
  logic [7:0] t_char;
  logic       accept, bad_req, hs, eop_hs;
  logic [7:0] next_byte;

  logic       ready_d, err_d, valid_d, sop_d, eop_d;
  logic [7:0] data_d;

  function automatic logic [23:0] bcd_inc(input logic [23:0] v);
    logic [23:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    for (int d = 0; d < 6; d++) begin
      if (carry) begin
        if (r[d*4 +: 4] == 4'd9) begin
          r[d*4 +: 4] = 4'd0;
        end else begin
          r[d*4 +: 4] = r[d*4 +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    // 999999 rolls to 000001: a sequence number of zero is never issued
    if (carry) r = 24'h000001;
    return r;
  endfunction

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  function automatic logic [7:0] dec_char(input logic [3:0] n);
    return 8'h30 + {4'h0, n};
  endfunction

  function automatic logic [7:0] frame_byte(input logic [5:0]  i,
                                            input logic [7:0]  t,
                                            input logic [23:0] sn,
                                            input logic [7:0]  h,
                                            input logic [7:0]  cs);
    logic [7:0] b;
    logic [7:0] d_hun, d_ten, d_one;
    d_hun = cs / 8'd100;
    d_ten = (cs / 8'd10) % 8'd10;
    d_one = cs % 8'd10;
    b     = 8'h00;
    case (i)
      6'd0:  b = "8";
      6'd1:  b = "=";
      6'd2:  b = "F";
      6'd3:  b = "I";
      6'd4:  b = "X";
      6'd5:  b = ".";
      6'd6:  b = "4";
      6'd7:  b = ".";
      6'd8:  b = "2";
      6'd9:  b = SOH;
      6'd10: b = "9";
      6'd11: b = "=";
      6'd12: b = "0";
      6'd13: b = "2";
      6'd14: b = "1";
      6'd15: b = SOH;
      6'd16: b = "3";
      6'd17: b = "5";
      6'd18: b = "=";
      6'd19: b = t;
      6'd20: b = SOH;
      6'd21: b = "3";
      6'd22: b = "4";
      6'd23: b = "=";
      6'd24: b = dec_char(sn[23:20]);
      6'd25: b = dec_char(sn[19:16]);
      6'd26: b = dec_char(sn[15:12]);
      6'd27: b = dec_char(sn[11:8]);
      6'd28: b = dec_char(sn[7:4]);
      6'd29: b = dec_char(sn[3:0]);
      6'd30: b = SOH;
      6'd31: b = "5";
      6'd32: b = "6";
      6'd33: b = "=";
      6'd34: b = hex_char(h[7:4]);
      6'd35: b = hex_char(h[3:0]);
      6'd36: b = SOH;
      6'd37: b = "1";
      6'd38: b = "0";
      6'd39: b = "=";
      6'd40: b = 8'h30 + d_hun;
      6'd41: b = 8'h30 + d_ten;
      6'd42: b = 8'h30 + d_one;
      6'd43: b = SOH;
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  always_comb begin
    code_ok = 1'b1;
    t_char  = 8'h00;
    case (create_message_i)
      4'd1:    t_char = "A";
      4'd2:    t_char = "0";
      4'd3:    t_char = "2";
      4'd4:    t_char = "5";
      4'd5:    t_char = "4";
      4'd6:    t_char = "4";
      default: code_ok = 1'b0;
    endcase
  end

  assign accept    = (state_q == IDLE) && initiate_msg_i && code_ok;
  assign bad_req   = (state_q == IDLE) && initiate_msg_i && !code_ok;
  assign hs        = valid_o && ready_i;
  assign eop_hs    = hs && eop_o;
  assign next_byte = frame_byte(idx_q + 6'd1, t_q, snap_q, 8'(host_q), csum_q);

  assign dbg_state_o = (state_q == SEND);

  // FSM: state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = SEND;
      SEND:    if (eop_hs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM: next values of the registered outputs
  always_comb begin
    valid_d = valid_o;
    sop_d   = sop_o;
    eop_d   = eop_o;
    data_d  = data_o;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          valid_d = 1'b1;
          sop_d   = 1'b1;
          eop_d   = 1'b0;
          data_d  = frame_byte(6'd0, t_q, snap_q, 8'(host_q), csum_q);
        end else if (bad_req) begin
          err_d = 1'b1;
        end
      end
      SEND: begin
        if (eop_hs) begin
          valid_d = 1'b0;
          sop_d   = 1'b0;
          eop_d   = 1'b0;
          data_d  = 8'h00;
        end else if (hs) begin
          sop_d  = 1'b0;
          eop_d  = (idx_q + 6'd1 == LAST_IDX);
          data_d = next_byte;
        end
      end
      default: ;
    endcase
    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ready_o <= 1'b1;
      err_o   <= 1'b0;
      data_o  <= 8'h00;
      valid_o <= 1'b0;
      sop_o   <= 1'b0;
      eop_o   <= 1'b0;
    end else begin
      ready_o <= ready_d;
      err_o   <= err_d;
      data_o  <= data_d;
      valid_o <= valid_d;
      sop_o   <= sop_d;
      eop_o   <= eop_d;
    end
  end

  // Frame fields are frozen at accept; the checksum folds in bytes 0..36 as they leave
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx_q  <= 6'd0;
      t_q    <= 8'h00;
      snap_q <= 24'h000001;
      host_q <= '0;
      csum_q <= 8'h00;
    end else if (accept) begin
      idx_q  <= 6'd0;
      t_q    <= t_char;
      snap_q <= seq_all[host_i];
      host_q <= host_i;
      csum_q <= 8'h00;
    end else if (hs) begin
      if (idx_q <= CS_LAST) csum_q <= csum_q + data_o;
      idx_q <= eop_o ? 6'd0 : idx_q + 6'd1;
    end
  end

  // Per-host sequence counters; an explicit reset beats a same-cycle end-of-frame increment
  for (genvar h = 0; h < NHOST; h++) begin : g_host
    logic [23:0] seq_q;
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        seq_q <= 24'h000001;
      end else if (seq_reset_i && (seq_reset_host_i == HOST_W'(h))) begin
        seq_q <= 24'h000001;
      end else if (eop_hs && (host_q == HOST_W'(h))) begin
        seq_q <= bcd_inc(seq_q);
      end
    end
    assign seq_all[h] = seq_q;
  end

endmodule

// File: tb/tb_fix_message_tx.sv
// Self-checking bench for fix_message_tx: a frame model fills an expected-byte queue at
// request time and a negedge monitor compares every presented byte against its head.
module tb_fix_message_tx;
  localparam int HOST_W = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              initiate_msg_i;
  logic [3:0]        create_message_i;
  logic [HOST_W-1:0] host_i;
  logic              seq_reset_i;
  logic [HOST_W-1:0] seq_reset_host_i;
  logic              ready_o;
  logic              err_o;
  logic [7:0]        data_o;
  logic              valid_o;
  logic              sop_o;
  logic              eop_o;
  logic              ready_i;
  logic              dbg_state_o;

  int         n_checks = 0;
  int         n_pass   = 0;
  logic [7:0] exp_q[$];
  logic [7:0] rx [44];
  int         mon_pos  = 0;
  int         seq_m [16];
  bit         stall_en = 1'b0;
  int         frame_pos, frame_cs;

  fix_message_tx #(.HOST_W(HOST_W)) dut (
    .clk              (clk),
    .rst              (rst),
    .initiate_msg_i   (initiate_msg_i),
    .create_message_i (create_message_i),
    .host_i           (host_i),
    .seq_reset_i      (seq_reset_i),
    .seq_reset_host_i (seq_reset_host_i),
    .ready_o          (ready_o),
    .err_o            (err_o),
    .data_o           (data_o),
    .valid_o          (valid_o),
    .sop_o            (sop_o),
    .eop_o            (eop_o),
    .ready_i          (ready_i),
    .dbg_state_o      (dbg_state_o)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_checks);
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // frame model
  function automatic int pow10(input int d);
    int p = 1;
    for (int i = 0; i < d; i++) p = p * 10;
    return p;
  endfunction

  function automatic logic [7:0] hex_c(input int n);
    return (n < 10) ? 8'(48 + n) : 8'(55 + n);
  endfunction

  function automatic logic [7:0] type_char(input int code);
    case (code)
      1:       return "A";
      2:       return "0";
      3:       return "2";
      4:       return "5";
      default: return "4";
    endcase
  endfunction

  task automatic push_b(input logic [7:0] b);
    exp_q.push_back(b);
    if (frame_pos <= 36) frame_cs = frame_cs + int'(b);
    frame_pos++;
  endtask

  task automatic push_s(input string s);
    for (int i = 0; i < s.len(); i++) push_b(s[i]);
  endtask

  task automatic push_frame(input logic [7:0] t, input int seq, input int host);
    int cs;
    frame_pos = 0;
    frame_cs  = 0;
    push_s("8=FIX.4.2"); push_b(8'h01);
    push_s("9=021");     push_b(8'h01);
    push_s("35=");       push_b(t); push_b(8'h01);
    push_s("34=");
    for (int d = 5; d >= 0; d--) push_b(8'(48 + (seq / pow10(d)) % 10));
    push_b(8'h01);
    push_s("56=");       push_b(hex_c(host / 16)); push_b(hex_c(host % 16)); push_b(8'h01);
    cs = frame_cs % 256;
    push_s("10=");
    push_b(8'(48 + cs / 100)); push_b(8'(48 + (cs / 10) % 10)); push_b(8'(48 + cs % 10));
    push_b(8'h01);
  endtask

  // driver tasks
  task automatic send_req(input int code, input int host);
    int n = 0;
    while (ready_o !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("req_wait_ready", 32'(ready_o), 1);
    if (code >= 1 && code <= 6) begin
      push_frame(type_char(code), seq_m[host], host);
      seq_m[host] = (seq_m[host] == 999999) ? 1 : seq_m[host] + 1;
    end
    initiate_msg_i   = 1'b1;
    create_message_i = 4'(code);
    host_i           = HOST_W'(host);
    @(posedge clk);
    #1;
    initiate_msg_i = 1'b0;
  endtask

  task automatic wait_ready(output int k);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (ready_o !== 1'b1 && k < 3000);
    check("ready_timeout", 32'(k < 3000), 1);
  endtask

  task automatic wait_pos(input int p);
    int n = 0;
    while (mon_pos < p && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("pos_timeout", 32'(n < 3000), 1);
  endtask

  task automatic pulse_seq_reset(input int host);
    seq_reset_host_i = HOST_W'(host);
    seq_reset_i      = 1'b1;
    @(posedge clk);
    #1;
    seq_reset_i = 1'b0;
  endtask

  // downstream ready generator
  initial begin
    ready_i = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      ready_i = stall_en ? ($urandom_range(0, 2) != 0) : 1'b1;
    end
  end

  // scoreboard monitor
  initial begin
    forever begin
      @(negedge clk);
      if (rst === 1'b1 && valid_o === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("spurious_valid", 32'(valid_o), 0);
        end else begin
          check($sformatf("data[%0d]", mon_pos), 32'(data_o), 32'(exp_q[0]));
          check($sformatf("sop[%0d]", mon_pos), 32'(sop_o), 32'(mon_pos == 0));
          check($sformatf("eop[%0d]", mon_pos), 32'(eop_o), 32'(mon_pos == 43));
          if (ready_i) begin
            rx[mon_pos] = data_o;
            void'(exp_q.pop_front());
            mon_pos = (mon_pos == 43) ? 0 : mon_pos + 1;
          end
        end
      end
    end
  end

  initial begin
    int k;
    int n;
    rst              = 1'b0;
    initiate_msg_i   = 1'b0;
    create_message_i = 4'd0;
    host_i           = '0;
    seq_reset_i      = 1'b0;
    seq_reset_host_i = '0;
    for (int h = 0; h < 16; h++) seq_m[h] = 1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 32'(ready_o), 1);
    check("rst_err",   32'(err_o), 0);
    check("rst_valid", 32'(valid_o), 0);
    check("rst_sop",   32'(sop_o), 0);
    check("rst_eop",   32'(eop_o), 0);
    check("rst_data",  32'(data_o), 0);
    check("rst_state", 32'(dbg_state_o), 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;

    // logon to host 3, then an immediate heartbeat to the same host
    send_req(1, 3);
    @(negedge clk);
    check("first_valid", 32'(valid_o), 1);
    check("first_sop",   32'(sop_o), 1);
    check("first_state", 32'(dbg_state_o), 1);
    check("busy_ready",  32'(ready_o), 0);
    wait_ready(k);
    check("logon_latency", 32'(k + 1), 45);
    check("logon_type",    32'(rx[19]), 32'("A"));
    check("logon_seq",     {8'h00, rx[27], rx[28], rx[29]}, {8'h00, "001"});
    check("logon_host",    {16'h0000, rx[34], rx[35]}, {16'h0000, "03"});
    check("logon_cs",      {8'h00, rx[40], rx[41], rx[42]}, {8'h00, "226"});

    send_req(2, 3);
    wait_ready(k);
    check("hb_latency", 32'(k), 45);
    check("hb_type",    32'(rx[19]), 32'("0"));
    check("hb_seq",     {8'h00, rx[27], rx[28], rx[29]}, {8'h00, "002"});
    check("hb_cs",      {8'h00, rx[40], rx[41], rx[42]}, {8'h00, "210"});

    send_req(1, 5);
    wait_ready(k);
    check("h5_seq",  {8'h00, rx[27], rx[28], rx[29]}, {8'h00, "001"});
    check("h5_host", 32'(rx[35]), 32'("5"));

    // resendReq under random stalls; mid-frame seq reset must not touch the snapshot
    stall_en = 1'b1;
    send_req(3, 3);
    wait_pos(25);
    pulse_seq_reset(3);
    wait_ready(k);
    stall_en = 1'b0;
    check("stall_seq_snapshot", 32'(rx[29]), 32'("3"));
    seq_m[3] = 2;  // reset to 000001 mid-frame, then advanced by the frame's end
    send_req(2, 3);
    wait_ready(k);
    check("after_reset_seq", 32'(rx[29]), 32'("2"));

    // remaining codes to random hosts
    for (int i = 0; i < 3; i++) begin
      send_req(4 + i, int'($urandom_range(1, 15)));
      wait_ready(k);
      check("code_type", 32'(rx[19]), 32'(type_char(4 + i)));
    end

    // counter wrap on host 0, preloaded to 999999
    @(posedge clk);
    #1;
    force dut.g_host[0].seq_q = 24'h999999;
    @(posedge clk);
    #1;
    release dut.g_host[0].seq_q;
    seq_m[0] = 999999;
    send_req(2, 0);
    wait_ready(k);
    check("wrap_pre", {8'h00, rx[24], rx[25], rx[26]}, {8'h00, "999"});
    send_req(1, 0);
    wait_ready(k);
    check("wrap_post", {8'h00, rx[27], rx[28], rx[29]}, {8'h00, "001"});
    check("wrap_post_hi", 32'(rx[24]), 32'("0"));

    // seq reset coinciding with the end-of-frame increment on host 0
    send_req(2, 0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(valid_o === 1'b1 && eop_o === 1'b1) && n < 200);
    check("eop_found", 32'(n < 200), 1);
    pulse_seq_reset(0);
    wait_ready(k);
    seq_m[0] = 1;
    send_req(2, 0);
    wait_ready(k);
    check("eop_reset_seq", {8'h00, rx[27], rx[28], rx[29]}, {8'h00, "001"});

    // unsupported codes: single err pulse, no bytes, counter untouched
    send_req(7, 6);
    @(negedge clk);
    check("err7_pulse", 32'(err_o), 1);
    check("err7_valid", 32'(valid_o), 0);
    check("err7_ready", 32'(ready_o), 1);
    @(negedge clk);
    check("err7_once",  32'(err_o), 0);
    send_req(0, 6);
    @(negedge clk);
    check("err0_pulse", 32'(err_o), 1);
    send_req(1, 6);
    wait_ready(k);
    check("err_next_accept", 32'(k), 45);
    check("err_seq",         32'(rx[29]), 32'("1"));

    // reset in the middle of a frame
    send_req(2, 9);
    wait_pos(20);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("midrst_valid", 32'(valid_o), 0);
    check("midrst_sop",   32'(sop_o), 0);
    check("midrst_eop",   32'(eop_o), 0);
    check("midrst_data",  32'(data_o), 0);
    check("midrst_ready", 32'(ready_o), 1);
    check("midrst_err",   32'(err_o), 0);
    exp_q.delete();
    mon_pos = 0;
    for (int h = 0; h < 16; h++) seq_m[h] = 1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    send_req(2, 9);
    wait_ready(k);
    check("midrst_seq", {8'h00, rx[27], rx[28], rx[29]}, {8'h00, "001"});

    repeat (3) @(negedge clk);
    check("exp_q_empty", 32'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
